// File: rtl/band_pass_filter_n_if.sv
// Frame-trigger, sample and status bundle for band_pass_filter_n.
// The master modport drives the frame clock, samples and controls; the slave is the filter.
interface band_pass_filter_n_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int SHIFT_W  = 5
) ();
  logic                       AUD_DACLRCK;
  logic [CHANNELS*WIDTH-1:0]  audio_in;
  logic [SHIFT_W-1:0]         hp_shift;
  logic [SHIFT_W-1:0]         lp_shift;
  logic                       bypass;
  logic [CHANNELS*WIDTH-1:0]  audio_out;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output AUD_DACLRCK, audio_in, hp_shift, lp_shift, bypass,
    input  audio_out, out_valid, busy, overrun
  );

  modport slave (
    input  AUD_DACLRCK, audio_in, hp_shift, lp_shift, bypass,
    output audio_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/band_pass_filter_n.sv
// N-channel first-order HP->LP band-pass filter, one shared datapath sequenced once per frame.
// Define BAND_PASS_SATURATE_EN to clamp outputs to WIDTH bits instead of wrapping.
module band_pass_filter_n #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32,
  parameter int SHIFT_W  = 5
) (
  input logic                 AUD_BCLK,
  input logic                 reset,
  band_pass_filter_n_if.slave bus
);

  localparam int S  = WIDTH + 2;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, HP, LP, DONE} state_t;

  state_t state, state_n;

  logic                      lrck_d;
  logic                      frame_edge;
  logic [CW-1:0]             ch;
  logic                      last_ch;
  logic [SHIFT_W-1:0]        hp_sh, lp_sh;
  logic                      byp_q;
  logic signed [WIDTH-1:0]   snap   [CHANNELS];
  logic signed [WIDTH-1:0]   shadow [CHANNELS];
  logic signed [S-1:0]       s1     [CHANNELS];
  logic signed [S-1:0]       s2     [CHANNELS];
  logic signed [S-1:0]       hp_q;
  logic [CHANNELS*WIDTH-1:0] out_q;

  logic signed [S-1:0]       x_ext, hp_diff, s1_new, lp_diff, s2_new;
  logic signed [WIDTH-1:0]   y_rule, out_val;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] v);
    if (32'(v) > 32'(WIDTH - 1))
      return SHIFT_W'(WIDTH - 1);
    return v;
  endfunction

  assign frame_edge = bus.AUD_DACLRCK & ~lrck_d;
  assign last_ch    = (ch == CW'(CHANNELS - 1));

  always_comb begin
    x_ext   = S'(snap[ch]);
    hp_diff = x_ext - s1[ch];
    s1_new  = s1[ch] + (hp_diff >>> hp_sh);
    lp_diff = hp_q - s2[ch];
    s2_new  = s2[ch] + (lp_diff >>> lp_sh);
`ifdef BAND_PASS_SATURATE_EN
    if (s2_new > S'({3'b000, {(WIDTH-1){1'b1}}}))
      y_rule = {1'b0, {(WIDTH-1){1'b1}}};
    else if (s2_new < S'({3'b111, {(WIDTH-1){1'b0}}}))
      y_rule = {1'b1, {(WIDTH-1){1'b0}}};
    else
      y_rule = s2_new[WIDTH-1:0];
`else
    y_rule = s2_new[WIDTH-1:0];
`endif
    out_val = byp_q ? snap[ch] : y_rule;
  end

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (frame_edge) state_n = HP;
      HP:      state_n = LP;
      LP:      state_n = last_ch ? DONE : HP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // audio_out is loaded on the final LP cycle (last channel merged in directly)
  // so the new frame is already visible while DONE raises out_valid.
  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      lrck_d <= 1'b0;
      ch     <= '0;
      hp_sh  <= '0;
      lp_sh  <= '0;
      byp_q  <= 1'b0;
      snap   <= '{default: '0};
      shadow <= '{default: '0};
      s1     <= '{default: '0};
      s2     <= '{default: '0};
      hp_q   <= '0;
      out_q  <= '0;
    end else begin
      lrck_d <= bus.AUD_DACLRCK;
      case (state)
        IDLE: if (frame_edge) begin
          for (int unsigned k = 0; k < CHANNELS; k++)
            snap[k] <= bus.audio_in[k*WIDTH +: WIDTH];
          hp_sh <= clamp_shift(bus.hp_shift);
          lp_sh <= clamp_shift(bus.lp_shift);
          byp_q <= bus.bypass;
          ch    <= '0;
        end
        HP: begin
          s1[ch] <= s1_new;
          hp_q   <= hp_diff;
        end
        LP: begin
          s2[ch]     <= s2_new;
          shadow[ch] <= out_val;
          if (last_ch) begin
            for (int unsigned k = 0; k < CHANNELS; k++)
              out_q[k*WIDTH +: WIDTH] <= (CW'(k) == ch) ? out_val : shadow[k];
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.audio_out = out_q;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = frame_edge & (state != IDLE);

endmodule

// File: tb/tb_band_pass_filter_n.sv
// Scoreboard bench for band_pass_filter_n: directed frames plus randomized frames
// against an arithmetic reference model of the HP->LP recurrences.
module tb_band_pass_filter_n;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  band_pass_filter_n_if #(.CHANNELS(CH), .WIDTH(W), .SHIFT_W(SW)) bus ();

  band_pass_filter_n #(.CHANNELS(CH), .WIDTH(W), .SHIFT_W(SW)) dut (
    .AUD_BCLK (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    logic [CH*W-1:0] data;
    int              at;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint m_s1[CH];
  longint m_s2[CH];
  int     vectors   = 0;
  int     errors    = 0;
  int     ovr_count = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint out_rule(input longint s);
    logic [W-1:0] t;
`ifdef BAND_PASS_SATURATE_EN
    longint hi = (longint'(1) <<< (W-1)) - 1;
    longint lo = -(longint'(1) <<< (W-1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    t = W'(s);
    return longint'($signed(t));
`endif
  endfunction

  function automatic logic [CH*W-1:0] model_frame(input logic [CH*W-1:0] ain,
                                                  input logic [SW-1:0] hs, input logic [SW-1:0] ls,
                                                  input logic byp);
    logic [CH*W-1:0]   r;
    logic signed [W-1:0] xs;
    int     ha = (int'(hs) > W-1) ? W-1 : int'(hs);
    int     la = (int'(ls) > W-1) ? W-1 : int'(ls);
    longint x, hp;
    for (int k = 0; k < CH; k++) begin
      xs = ain[k*W +: W];
      x  = longint'(xs);
      hp = x - m_s1[k];
      m_s1[k] = m_s1[k] + ((x - m_s1[k]) >>> ha);
      m_s2[k] = m_s2[k] + ((hp - m_s2[k]) >>> la);
      r[k*W +: W] = byp ? xs : W'(out_rule(m_s2[k]));
    end
    return r;
  endfunction

  function automatic logic [CH*W-1:0] rnd_vec();
    logic [CH*W-1:0] v;
    for (int k = 0; k < CH; k++) v[k*W +: W] = W'($urandom());
    return v;
  endfunction

  function automatic logic [CH*W-1:0] pack2(input int c1, input int c0);
    logic [CH*W-1:0] v = '0;
    v[0 +: W] = W'(c0);
    v[W +: W] = W'(c1);
    return v;
  endfunction

  function automatic longint ch_out(input int k);
    logic signed [W-1:0] t = bus.audio_out[k*W +: W];
    return longint'(t);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) begin
      m_s1[k] = 0;
      m_s2[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_model();
    sb.delete();
  endtask

  // Called just after a rising edge; raises the frame clock and books the expected frame.
  task automatic start_edge(input logic [CH*W-1:0] ain, input logic [SW-1:0] hs,
                            input logic [SW-1:0] ls, input logic byp);
    exp_t e;
    bus.audio_in    = ain;
    bus.hp_shift    = hs;
    bus.lp_shift    = ls;
    bus.bypass      = byp;
    bus.AUD_DACLRCK = 1'b1;
    e.data = model_frame(ain, hs, ls, byp);
    e.at   = cyc + 1 + 2*CH;
    sb.push_back(e);
  endtask

  task automatic frame(input logic [CH*W-1:0] ain, input logic [SW-1:0] hs,
                       input logic [SW-1:0] ls, input logic byp, input int gap);
    start_edge(ain, hs, ls, byp);
    tick(1);
    check("busy_rise", bus.busy, 1);
    bus.AUD_DACLRCK = 1'b0;
    bus.audio_in    = rnd_vec();
    bus.hp_shift    = SW'($urandom());
    bus.lp_shift    = SW'($urandom());
    bus.bypass      = 1'($urandom());
    tick(5 + gap);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.overrun) ovr_count++;
      if (bus.out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (bus.audio_out !== mon_e.data || cyc != mon_e.at) begin
            errors++;
            $display("FAIL frame_out: got %h at cycle %0d, expected %h at cycle %0d",
                     bus.audio_out, cyc, mon_e.data, mon_e.at);
          end
        end
      end
    end
  end

  initial begin
    bus.AUD_DACLRCK = 1'b0;
    bus.audio_in    = '0;
    bus.hp_shift    = '0;
    bus.lp_shift    = '0;
    bus.bypass      = 1'b0;
    clear_model();
    tick(3);
    rst = 1'b0;
    check("rst_audio_out", bus.audio_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);

    frame('0, 0, 0, 0, 0);
    check("zero_frame_out", bus.audio_out, 0);
    check("no_overrun", ovr_count, 0);

    // DC step through HP (shift 4) with transparent LP
    frame(pack2(0, 1000), 4, 0, 0, 0);
    check("dc_frame1", ch_out(0), 1000);
    frame(pack2(0, 1000), 4, 0, 0, 0);
    check("dc_frame2", ch_out(0), 938);
    frame(pack2(0, 1000), 4, 0, 0, 2);

    // LP step with HP shift clamped to W-1
    do_reset();
    frame(pack2(0, 1024), 31, 1, 0, 0);
    check("lp_step1", ch_out(0), 512);
    frame(pack2(0, 1024), 31, 1, 0, 0);
    check("lp_step2", ch_out(0), 768);
    frame(pack2(0, 1024), 31, 1, 0, 0);
    check("lp_step3", ch_out(0), 896);

    for (int i = 0; i < 3; i++) begin
      frame(pack2(-5, int'($urandom_range(0, 2000))), SW'($urandom_range(0, 8)),
            SW'($urandom_range(0, 8)), 1, 0);
      check("bypass_ch1", ch_out(1), -5);
    end
    frame(pack2(-5, 300), 3, 2, 0, 1);

    // Second edge three cycles into a frame is dropped
    start_edge(rnd_vec(), 2, 3, 0);
    tick(1);
    bus.AUD_DACLRCK = 1'b0;
    tick(2);
    bus.AUD_DACLRCK = 1'b1;
    #1;
    check("overrun_pulse", bus.overrun, 1);
    tick(1);
    bus.AUD_DACLRCK = 1'b0;
    check("overrun_count", ovr_count, 1);
    tick(2);

    do_reset();
    frame(pack2(0, 32767), 0, 0, 0, 0);
    check("sat_pos", ch_out(0), 32767);
    frame(pack2(0, -32768), 0, 0, 0, 0);
`ifdef BAND_PASS_SATURATE_EN
    check("sat_neg", ch_out(0), -32768);
`else
    check("wrap_neg", ch_out(0), 1);
`endif

    // Reset mid-frame discards the frame
    start_edge(rnd_vec(), 1, 1, 0);
    tick(1);
    bus.AUD_DACLRCK = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_out", bus.audio_out, 0);
    tick(1);
    rst = 1'b0;
    clear_model();
    sb.delete();
    tick(10);
    check("midrst_out_hold", bus.audio_out, 0);

    for (int i = 0; i < 40; i++)
      frame(rnd_vec(), SW'($urandom_range(0, 31)), SW'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    tick(10);
    check("sb_drained", sb.size(), 0);
    check("overrun_total", ovr_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
